sensor_nivel_multi: RTL and testbench

- Parametrised water-level check for the coffee reservoir, driven by the main control FSM.
- On each `medir` request it runs AMOSTRAS ultrasonic samples through an internal `interface_hcsr04`, keeping the largest distance read (worst case, least water).
- It compares that distance against a per-mode threshold chosen from NUM_MODOS cup sizes.
- Each sample gets its own timeout, a bounded retry budget, and a forced sensor reset on failure. Result is a single `pronto` pulse with `suficiente`/`timeout`.

---
 rtl/sensor_nivel_multi_if.sv | 36 +++
 rtl/sensor_nivel_multi.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_sensor_nivel_multi.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_nivel_multi_if.sv
// ---------------------------------------------------------------------------
// sensor_nivel_multi_if
// Handshake and result bundle between the main control FSM and the
// water-level checker (sensor_nivel_multi).
//   medir      : start request (controller -> checker)
//   modo       : cup size, MODO_W bits (controller -> checker)
//   ocupado    : checker busy
//   pronto     : one-cycle result strobe
//   suficiente : enough water (valid with pronto, then held)
//   timeout    : one-cycle strobe with pronto when retries ran out
//   medida_max : largest BCD distance of the last completed request
//   db_estado  : checker FSM state code, for debug
// Modports: master = controller side, slave = checker side.
// ---------------------------------------------------------------------------
interface sensor_nivel_multi_if #(
  parameter int MODO_W = 2
);
  logic              medir;
  logic [MODO_W-1:0] modo;
  logic              ocupado;
  logic              pronto;
  logic              suficiente;
  logic              timeout;
  logic [11:0]       medida_max;
  logic [3:0]        db_estado;

  modport master (
    output medir, modo,
    input  ocupado, pronto, suficiente, timeout, medida_max, db_estado
  );

  modport slave (
    input  medir, modo,
    output ocupado, pronto, suficiente, timeout, medida_max, db_estado
  );
endinterface

// File: rtl/sensor_nivel_multi.sv
// ---------------------------------------------------------------------------
// sensor_nivel_multi
// Water-level check for the coffee reservoir. Each accepted request takes
// AMOSTRAS ultrasonic samples through an internal HC-SR04 front end, keeps
// the largest distance (least water) and compares it with the threshold of
// the selected cup size. Every sample has its own timeout and a bounded
// retry budget; a failed attempt forces a reset of the front end.
//
// Ports:
//   clock   : system clock (50 MHz)
//   reset   : asynchronous, active-low reset
//   echo    : HC-SR04 echo input
//   trigger : HC-SR04 trigger output
//   ctrl    : sensor_nivel_multi_if.slave (medir, modo, ocupado, pronto,
//             suficiente, timeout, medida_max, db_estado)
//
// Optional build macro: SENSOR_NIVEL_VALIDA_BCD_EN -- when defined, a
// reading with any nibble above 9 is discarded and handled as a failed
// attempt. When undefined every reading is accepted as-is.
//
// CICLOS_TRIG / CICLOS_CM size the front end: trigger pulse width and echo
// cycles per centimetre (58.8 us/cm at 50 MHz).
// ---------------------------------------------------------------------------

// HC-SR04 front end: on medir_i emits a CICLOS_TRIG-cycle trigger, then
// measures the echo pulse width and converts it to centimetres in BCD
// (three digits, saturating at 999). It waits for the echo indefinitely;
// the caller owns the timeout and resets this block to abandon an attempt.
module interface_hcsr04 #(
  parameter int CICLOS_TRIG = 500,
  parameter int CICLOS_CM   = 2941
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir_i,
  input  logic        echo_i,
  output logic        trigger_o,
  output logic        pronto_o,
  output logic [11:0] medida_o
);
  localparam int TRIG_W = $clog2(CICLOS_TRIG + 1);
  localparam int DIV_W  = $clog2(CICLOS_CM + 1);
  localparam logic [TRIG_W-1:0] TRIG_LIM = TRIG_W'(CICLOS_TRIG - 1);
  localparam logic [DIV_W-1:0]  DIV_LIM  = DIV_W'(CICLOS_CM - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_ECO, S_FIM} hc_estado_t;

  hc_estado_t        estado_q, estado_d;
  logic [TRIG_W-1:0] trig_q, trig_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [11:0]       cm_q, cm_d;
  logic              viu_q, viu_d;
  logic              trigger_q;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  always_comb begin
    estado_d = estado_q;
    trig_d   = trig_q;
    div_d    = div_q;
    cm_d     = cm_q;
    viu_d    = viu_q;
    case (estado_q)
      S_IDLE: begin
        if (medir_i) begin
          trig_d   = '0;
          div_d    = '0;
          cm_d     = '0;
          viu_d    = 1'b0;
          estado_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (trig_q == TRIG_LIM) estado_d = S_ECO;
        else                    trig_d   = trig_q + 1'b1;
      end
      S_ECO: begin
        // Pulse width counted in whole centimetres while echo is high;
        // the falling edge after a seen pulse ends the measurement.
        if (echo_i) begin
          viu_d = 1'b1;
          if (div_q == DIV_LIM) begin
            div_d = '0;
            cm_d  = bcd_inc(cm_q);
          end else begin
            div_d = div_q + 1'b1;
          end
        end else if (viu_q) begin
          estado_d = S_FIM;
        end
      end
      S_FIM:   estado_d = S_IDLE;
      default: estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= S_IDLE;
      trig_q    <= '0;
      div_q     <= '0;
      cm_q      <= '0;
      viu_q     <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      trig_q    <= trig_d;
      div_q     <= div_d;
      cm_q      <= cm_d;
      viu_q     <= viu_d;
      // Registered so the sensor pin never sees decode glitches.
      trigger_q <= (estado_d == S_TRIG);
    end
  end

  assign trigger_o = trigger_q;
  assign pronto_o  = (estado_q == S_FIM);
  assign medida_o  = cm_q;  // stable until the next medir_i
endmodule

module sensor_nivel_multi #(
  parameter int MODO_W = 2,
  parameter logic [(2**MODO_W)*12-1:0] LIMITES = {12'h030, 12'h050, 12'h070, 12'h000},
  parameter int AMOSTRAS    = 4,
  parameter int TENTATIVAS  = 3,
  parameter int TIMEOUT_M   = 50000000,
  parameter int INTERVALO_M = 3000000,
  parameter int CNT_N       = 26,
  parameter int CICLOS_TRIG = 500,
  parameter int CICLOS_CM   = 2941
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 echo,
  output logic                 trigger,
  sensor_nivel_multi_if.slave  ctrl
);
  localparam int NUM_MODOS = 2**MODO_W;
  localparam logic [3:0]       AMOSTRAS_L   = 4'(AMOSTRAS);
  localparam logic [2:0]       TENTATIVAS_L = 3'(TENTATIVAS);
  localparam logic [CNT_N-1:0] TIMEOUT_LIM  = CNT_N'(TIMEOUT_M - 1);
  localparam logic [CNT_N-1:0] INTERV_LIM   = CNT_N'(INTERVALO_M - 1);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    PREPARA   = 4'd1,
    DISPARA   = 4'd2,
    ESPERA    = 4'd3,
    AMOSTRA   = 4'd4,
    FALHA     = 4'd5,
    INTERVALO = 4'd6,
    COMPARA   = 4'd7,
    ERRO      = 4'd8
  } estado_t;

  estado_t           estado_q, estado_d;
  logic [MODO_W-1:0] modo_q, modo_d;
  logic [3:0]        amostra_q, amostra_d;
  logic [2:0]        tentativa_q, tentativa_d;
  logic [11:0]       max_q, max_d;
  logic [11:0]       medida_max_q, medida_max_d;
  logic              suficiente_q, suficiente_d;
  logic [CNT_N-1:0]  cnt_q, cnt_d;
  logic              erro_to_q, erro_to_d;
  logic              rst_sensor_q;

  logic              sens_medir;
  logic              sens_pronto;
  logic [11:0]       sens_medida;
  logic              sens_rst_n;
  logic              amostra_ok;
  logic [11:0]       limite_sel;
  logic              cabe;

  // Threshold table unpacked from the packed parameter; 12'h000 = invalid.
  logic [11:0] limite_tab [NUM_MODOS];
  genvar gi;
  for (gi = 0; gi < NUM_MODOS; gi++) begin : g_lim
    assign limite_tab[gi] = LIMITES[12*gi +: 12];
  end
  assign limite_sel = limite_tab[modo_q];
  // Unsigned compare orders BCD values correctly.
  assign cabe = (max_q <= limite_sel);

`ifdef SENSOR_NIVEL_VALIDA_BCD_EN
  logic [2:0] nibble_ok;
  for (gi = 0; gi < 3; gi++) begin : g_bcd
    assign nibble_ok[gi] = (sens_medida[4*gi +: 4] <= 4'd9);
  end
  assign amostra_ok = &nibble_ok;
`else
  assign amostra_ok = 1'b1;
`endif

  always_comb begin
    estado_d     = estado_q;
    modo_d       = modo_q;
    amostra_d    = amostra_q;
    tentativa_d  = tentativa_q;
    max_d        = max_q;
    medida_max_d = medida_max_q;
    suficiente_d = suficiente_q;
    cnt_d        = cnt_q;
    erro_to_d    = erro_to_q;
    sens_medir   = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (ctrl.medir) begin
          modo_d       = ctrl.modo;
          amostra_d    = '0;
          tentativa_d  = '0;
          max_d        = '0;
          suficiente_d = 1'b0;
          erro_to_d    = 1'b0;
          estado_d     = PREPARA;
        end
      end
      PREPARA: begin
        if (limite_sel == 12'h000) estado_d = ERRO;
        else                       estado_d = DISPARA;
      end
      DISPARA: begin
        sens_medir = 1'b1;
        cnt_d      = '0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        cnt_d = cnt_q + 1'b1;
        // A reading landing on the last timeout cycle still counts.
        if (sens_pronto)               estado_d = AMOSTRA;
        else if (cnt_q == TIMEOUT_LIM) estado_d = FALHA;
      end
      AMOSTRA: begin
        cnt_d = '0;
        if (!amostra_ok) begin
          estado_d = FALHA;
        end else begin
          if (sens_medida > max_q) max_d = sens_medida;
          amostra_d   = amostra_q + 4'd1;
          tentativa_d = '0;
          if (amostra_q + 4'd1 == AMOSTRAS_L) estado_d = COMPARA;
          else                                estado_d = INTERVALO;
        end
      end
      FALHA: begin
        cnt_d       = '0;
        tentativa_d = tentativa_q + 3'd1;
        if (tentativa_q + 3'd1 == TENTATIVAS_L) begin
          erro_to_d = 1'b1;
          estado_d  = ERRO;
        end else begin
          estado_d  = INTERVALO;
        end
      end
      INTERVALO: begin
        if (cnt_q == INTERV_LIM) begin
          cnt_d    = '0;
          estado_d = DISPARA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPARA: begin
        suficiente_d = cabe;
        medida_max_d = max_q;
        estado_d     = OCIOSO;
      end
      ERRO: begin
        suficiente_d = 1'b0;
        erro_to_d    = 1'b0;
        estado_d     = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      modo_q       <= '0;
      amostra_q    <= '0;
      tentativa_q  <= '0;
      max_q        <= '0;
      medida_max_q <= '0;
      suficiente_q <= 1'b0;
      cnt_q        <= '0;
      erro_to_q    <= 1'b0;
      rst_sensor_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      modo_q       <= modo_d;
      amostra_q    <= amostra_d;
      tentativa_q  <= tentativa_d;
      max_q        <= max_d;
      medida_max_q <= medida_max_d;
      suficiente_q <= suficiente_d;
      cnt_q        <= cnt_d;
      erro_to_q    <= erro_to_d;
      // Flopped so the front end's asynchronous reset is glitch-free;
      // it is high exactly during the FALHA cycle.
      rst_sensor_q <= (estado_d == FALHA);
    end
  end

  assign sens_rst_n = reset & ~rst_sensor_q;

  interface_hcsr04 #(
    .CICLOS_TRIG (CICLOS_TRIG),
    .CICLOS_CM   (CICLOS_CM)
  ) u_hcsr04 (
    .clock     (clock),
    .reset     (sens_rst_n),
    .medir_i   (sens_medir),
    .echo_i    (echo),
    .trigger_o (trigger),
    .pronto_o  (sens_pronto),
    .medida_o  (sens_medida)
  );

  // Result is shown combinationally in COMPARA so it is valid with pronto.
  assign ctrl.ocupado    = (estado_q != OCIOSO);
  assign ctrl.pronto     = (estado_q == COMPARA) || (estado_q == ERRO);
  assign ctrl.timeout    = (estado_q == ERRO) && erro_to_q;
  assign ctrl.suficiente = (estado_q == COMPARA) ? cabe : suficiente_q;
  assign ctrl.medida_max = (estado_q == COMPARA) ? max_q : medida_max_q;
  assign ctrl.db_estado  = estado_q;
endmodule

// File: tb/tb_sensor_nivel_multi.sv
module tb_sensor_nivel_multi;
  localparam int AMOSTRAS    = 4;
  localparam int TENTATIVAS  = 3;
  localparam int TIMEOUT_M   = 200;
  localparam int INTERVALO_M = 20;
  localparam int CM          = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic echo  = 1'b0;
  logic trigger;

  sensor_nivel_multi_if #(.MODO_W(2)) bus ();

  sensor_nivel_multi #(
    .MODO_W(2), .AMOSTRAS(AMOSTRAS), .TENTATIVAS(TENTATIVAS),
    .TIMEOUT_M(TIMEOUT_M), .INTERVALO_M(INTERVALO_M), .CNT_N(8),
    .CICLOS_TRIG(4), .CICLOS_CM(CM)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .echo    (echo),
    .trigger (trigger),
    .ctrl    (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Sensor responses in decimal cm, one per trigger; -1 = no echo.
  int plan[$];
  int resp_q[$];

  // Observations gathered by the monitors.
  int obs_trig = 0, obs_falhas = 0, obs_pronto = 0, obs_to_alone = 0;
  logic obs_suf = 1'b0, obs_to = 1'b0;
  logic [11:0] obs_med = 12'h000;

  // Per-request deltas.
  int d_trig, d_falhas, d_pronto, d_to_alone;
  bit req_ok;

  // Reference model results.
  int exp_trig, exp_falhas;
  logic exp_suf, exp_to;
  logic [11:0] exp_med;
  logic [11:0] exp_last_med = 12'h000;
  int lim_dec[4] = '{0, 70, 50, 30};

  // Echo model: answers each trigger with the next planned distance.
  initial begin : echo_model
    int d;
    forever begin
      @(negedge trigger);
      if (resp_q.size() > 0) d = resp_q.pop_front();
      else                   d = -1;
      if (d > 0) begin
        repeat (2) @(posedge clock);
        #1 echo = 1'b1;
        repeat (d * CM) @(posedge clock);
        #1 echo = 1'b0;
      end
    end
  end

  always @(posedge trigger) obs_trig++;

  always @(negedge clock) begin
    if (bus.pronto === 1'b1) begin
      obs_pronto++;
      obs_suf = bus.suficiente;
      obs_to  = bus.timeout;
      obs_med = bus.medida_max;
    end
    if (bus.timeout === 1'b1 && bus.pronto !== 1'b1) obs_to_alone++;
    if (bus.db_estado === 4'd5) obs_falhas++;
  end

  function automatic logic [11:0] to_bcd(input int d);
    return 12'((d / 100) * 256 + ((d / 10) % 10) * 16 + (d % 10));
  endfunction

  // Request outcome from the behaviour rules, in decimal centimetres.
  task automatic model(input logic [1:0] m);
    int s, t, mx, k, d;
    s = 0; t = 0; mx = 0; k = 0;
    exp_falhas = 0; exp_to = 1'b0; exp_suf = 1'b0; exp_med = exp_last_med;
    if (lim_dec[m] != 0) begin
      while (1) begin
        d = (k < plan.size()) ? plan[k] : -1;
        k++;
        if (d < 0) begin
          t++;
          exp_falhas++;
          if (t == TENTATIVAS) begin exp_to = 1'b1; break; end
        end else begin
          s++;
          t = 0;
          if (d > mx) mx = d;
          if (s == AMOSTRAS) begin
            exp_suf = (mx <= lim_dec[m]);
            exp_med = to_bcd(mx);
            exp_last_med = exp_med;
            break;
          end
        end
      end
    end
    exp_trig = k;
  endtask

  // Issues one request and collects what happened (no checking here).
  task automatic run_request(input logic [1:0] m, input bit poke);
    int t0, f0, p0, a0, n;
    resp_q = plan;
    t0 = obs_trig; f0 = obs_falhas; p0 = obs_pronto; a0 = obs_to_alone;
    @(posedge clock); #1 bus.modo = m; bus.medir = 1'b1;
    @(posedge clock); #1 bus.medir = 1'b0;
    if (poke) begin
      bus.modo = ~m;
      repeat (3) @(posedge clock);
      #1 bus.medir = 1'b1;
      @(posedge clock); #1 bus.medir = 1'b0;
    end
    n = 0;
    while (obs_pronto == p0 && n < 5000) begin
      @(posedge clock);
      n++;
    end
    req_ok = (obs_pronto != p0);
    repeat (40) @(posedge clock);
    #1;
    d_trig = obs_trig - t0; d_falhas = obs_falhas - f0;
    d_pronto = obs_pronto - p0; d_to_alone = obs_to_alone - a0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++; if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL reset_ocupado got=%b want=0", bus.ocupado); end
    total++; if (bus.pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto got=%b want=0", bus.pronto); end
    total++; if (bus.suficiente !== 1'b0) begin bad++; $display("FAIL reset_suficiente got=%b want=0", bus.suficiente); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
    total++; if (bus.medida_max !== 12'h000) begin bad++; $display("FAIL reset_medida got=%h want=000", bus.medida_max); end
    total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL reset_estado got=%0d want=0", bus.db_estado); end
    total++; if (trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger got=%b want=0", trigger); end
    $display("test_reset: outputs checked under reset");
    @(posedge clock); #1 reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_uniform();
    plan = '{45, 45, 45, 45};
    run_request(2'b10, 1'b0);
    total++; if (!req_ok) begin bad++; $display("FAIL uniform_done got=no_pronto want=pronto"); end
    total++; if (d_pronto !== 1) begin bad++; $display("FAIL uniform_pronto got=%0d want=1", d_pronto); end
    total++; if (d_trig !== 4) begin bad++; $display("FAIL uniform_triggers got=%0d want=4", d_trig); end
    total++; if (obs_suf !== 1'b1) begin bad++; $display("FAIL uniform_suf got=%b want=1", obs_suf); end
    total++; if (obs_med !== 12'h045) begin bad++; $display("FAIL uniform_med got=%h want=045", obs_med); end
    total++; if (obs_to !== 1'b0) begin bad++; $display("FAIL uniform_timeout got=%b want=0", obs_to); end
    total++; if (bus.suficiente !== 1'b1) begin bad++; $display("FAIL uniform_suf_held got=%b want=1", bus.suficiente); end
    exp_last_med = 12'h045;
    $display("test_uniform: trig=%0d suf=%b med=%h", d_trig, obs_suf, obs_med);
  endtask

  task automatic test_max_modes();
    plan = '{40, 62, 51, 48};
    run_request(2'b10, 1'b0);
    total++; if (obs_med !== 12'h062) begin bad++; $display("FAIL max_m2_med got=%h want=062", obs_med); end
    total++; if (obs_suf !== 1'b0) begin bad++; $display("FAIL max_m2_suf got=%b want=0", obs_suf); end
    $display("test_max_modes m=2: med=%h suf=%b", obs_med, obs_suf);
    run_request(2'b01, 1'b0);
    total++; if (obs_med !== 12'h062) begin bad++; $display("FAIL max_m1_med got=%h want=062", obs_med); end
    total++; if (obs_suf !== 1'b1) begin bad++; $display("FAIL max_m1_suf got=%b want=1", obs_suf); end
    exp_last_med = 12'h062;
    $display("test_max_modes m=1: med=%h suf=%b", obs_med, obs_suf);
  endtask

  task automatic test_equality();
    plan = '{70, 70, 70, 70};
    run_request(2'b01, 1'b0);
    total++; if (obs_suf !== 1'b1) begin bad++; $display("FAIL equal_suf got=%b want=1", obs_suf); end
    total++; if (obs_med !== 12'h070) begin bad++; $display("FAIL equal_med got=%h want=070", obs_med); end
    exp_last_med = 12'h070;
    $display("test_equality: med=%h suf=%b", obs_med, obs_suf);
  endtask

  task automatic test_retries();
    plan = '{33, -1, -1, 41, 27, 12};
    run_request(2'b01, 1'b0);
    total++; if (d_trig !== 6) begin bad++; $display("FAIL retry_triggers got=%0d want=6", d_trig); end
    total++; if (d_falhas !== 2) begin bad++; $display("FAIL retry_resets got=%0d want=2", d_falhas); end
    total++; if (d_pronto !== 1) begin bad++; $display("FAIL retry_pronto got=%0d want=1", d_pronto); end
    total++; if (obs_to !== 1'b0) begin bad++; $display("FAIL retry_timeout got=%b want=0", obs_to); end
    total++; if (obs_med !== 12'h041) begin bad++; $display("FAIL retry_med got=%h want=041", obs_med); end
    exp_last_med = 12'h041;
    $display("test_retries: trig=%0d resets=%0d med=%h", d_trig, d_falhas, obs_med);
  endtask

  task automatic test_exhaust();
    plan = '{20, -1, -1, -1};
    run_request(2'b01, 1'b0);
    total++; if (d_pronto !== 1) begin bad++; $display("FAIL exhaust_pronto got=%0d want=1", d_pronto); end
    total++; if (obs_to !== 1'b1) begin bad++; $display("FAIL exhaust_timeout got=%b want=1", obs_to); end
    total++; if (d_to_alone !== 0) begin bad++; $display("FAIL exhaust_to_alone got=%0d want=0", d_to_alone); end
    total++; if (obs_suf !== 1'b0) begin bad++; $display("FAIL exhaust_suf got=%b want=0", obs_suf); end
    total++; if (d_trig !== 4) begin bad++; $display("FAIL exhaust_triggers got=%0d want=4", d_trig); end
    total++; if (obs_med !== 12'h041) begin bad++; $display("FAIL exhaust_med got=%h want=041", obs_med); end
    $display("test_exhaust: to=%b suf=%b trig=%0d", obs_to, obs_suf, d_trig);
  endtask

  task automatic test_invalid_mode();
    int t0;
    t0 = obs_trig;
    @(posedge clock); #1 bus.modo = 2'b00; bus.medir = 1'b1;
    @(posedge clock); #1 bus.medir = 1'b0;
    total++; if (bus.pronto !== 1'b0) begin bad++; $display("FAIL invalid_early got=%b want=0", bus.pronto); end
    @(posedge clock); #1;
    total++; if (bus.pronto !== 1'b1) begin bad++; $display("FAIL invalid_pronto got=%b want=1", bus.pronto); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL invalid_timeout got=%b want=0", bus.timeout); end
    total++; if (bus.suficiente !== 1'b0) begin bad++; $display("FAIL invalid_suf got=%b want=0", bus.suficiente); end
    total++; if (bus.db_estado !== 4'd8) begin bad++; $display("FAIL invalid_estado got=%0d want=8", bus.db_estado); end
    repeat (20) @(posedge clock); #1;
    total++; if (obs_trig - t0 !== 0) begin bad++; $display("FAIL invalid_triggers got=%0d want=0", obs_trig - t0); end
    total++; if (bus.medida_max !== exp_last_med) begin bad++; $display("FAIL invalid_med got=%h want=%h", bus.medida_max, exp_last_med); end
    $display("test_invalid_mode: pronto after 2 cycles, trig=%0d", obs_trig - t0);
  endtask

  task automatic test_busy_ignored();
    plan = '{10, 20, 65, 40};
    run_request(2'b01, 1'b1);
    total++; if (d_pronto !== 1) begin bad++; $display("FAIL busy_pronto got=%0d want=1", d_pronto); end
    total++; if (d_trig !== 4) begin bad++; $display("FAIL busy_triggers got=%0d want=4", d_trig); end
    total++; if (obs_suf !== 1'b1) begin bad++; $display("FAIL busy_suf got=%b want=1", obs_suf); end
    total++; if (obs_med !== 12'h065) begin bad++; $display("FAIL busy_med got=%h want=065", obs_med); end
    exp_last_med = 12'h065;
    $display("test_busy_ignored: pronto=%0d med=%h", d_pronto, obs_med);
  endtask

  task automatic test_reset_mid_request();
    int t0, p0, n;
    plan = '{45, 45, 45, 45};
    resp_q = plan;
    t0 = obs_trig; p0 = obs_pronto;
    @(posedge clock); #1 bus.modo = 2'b10; bus.medir = 1'b1;
    @(posedge clock); #1 bus.medir = 1'b0;
    n = 0;
    while (obs_trig - t0 < 3 && n < 3000) begin @(posedge clock); n++; end
    total++; if (obs_trig - t0 < 3) begin bad++; $display("FAIL midrst_third_trigger got=%0d want=3", obs_trig - t0); end
    repeat (10) @(posedge clock); #1;
    total++; if (bus.db_estado !== 4'd3) begin bad++; $display("FAIL midrst_in_espera got=%0d want=3", bus.db_estado); end
    @(posedge clock); #1 reset = 1'b0;
    #2;
    total++; if (bus.db_estado !== 4'd0) begin bad++; $display("FAIL midrst_estado got=%0d want=0", bus.db_estado); end
    total++; if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL midrst_ocupado got=%b want=0", bus.ocupado); end
    total++; if (bus.medida_max !== 12'h000) begin bad++; $display("FAIL midrst_med got=%h want=000", bus.medida_max); end
    total++; if (bus.suficiente !== 1'b0) begin bad++; $display("FAIL midrst_suf got=%b want=0", bus.suficiente); end
    exp_last_med = 12'h000;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    repeat (250) @(posedge clock);
    total++; if (obs_pronto !== p0) begin bad++; $display("FAIL midrst_no_pronto got=%0d want=%0d", obs_pronto, p0); end
    $display("test_reset_mid_request: reset in ESPERA of sample 3");
    plan = '{12, 28, 9, 17};
    model(2'b11);
    run_request(2'b11, 1'b0);
    total++; if (d_pronto !== 1) begin bad++; $display("FAIL fresh_pronto got=%0d want=1", d_pronto); end
    total++; if (obs_med !== exp_med) begin bad++; $display("FAIL fresh_med got=%h want=%h", obs_med, exp_med); end
    total++; if (obs_suf !== exp_suf) begin bad++; $display("FAIL fresh_suf got=%b want=%b", obs_suf, exp_suf); end
    $display("test_reset_mid_request: fresh med=%h suf=%b", obs_med, obs_suf);
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int it = 0; it < 8; it++) begin
      m = 2'($urandom_range(0, 3));
      if (it < 6 && m == 2'b00) m = 2'b01;
      plan.delete();
      for (int j = 0; j < 12; j++)
        plan.push_back(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 80)));
      model(m);
      run_request(m, 1'b0);
      total++; if (!req_ok) begin bad++; $display("FAIL rnd%0d_done got=no_pronto want=pronto", it); end
      total++; if (d_pronto !== 1) begin bad++; $display("FAIL rnd%0d_pronto got=%0d want=1", it, d_pronto); end
      total++; if (d_trig !== exp_trig) begin bad++; $display("FAIL rnd%0d_triggers got=%0d want=%0d", it, d_trig, exp_trig); end
      total++; if (d_falhas !== exp_falhas) begin bad++; $display("FAIL rnd%0d_resets got=%0d want=%0d", it, d_falhas, exp_falhas); end
      total++; if (obs_to !== exp_to) begin bad++; $display("FAIL rnd%0d_timeout got=%b want=%b", it, obs_to, exp_to); end
      total++; if (obs_suf !== exp_suf) begin bad++; $display("FAIL rnd%0d_suf got=%b want=%b", it, obs_suf, exp_suf); end
      total++; if (obs_med !== exp_med) begin bad++; $display("FAIL rnd%0d_med got=%h want=%h", it, obs_med, exp_med); end
      $display("test_random %0d: modo=%0d trig=%0d resets=%0d to=%b suf=%b med=%h",
               it, m, d_trig, d_falhas, obs_to, obs_suf, obs_med);
    end
  endtask

  initial begin
    bus.medir = 1'b0;
    bus.modo  = 2'b00;
    test_reset();
    test_uniform();
    test_max_modes();
    test_equality();
    test_retries();
    test_exhaust();
    test_invalid_mode();
    test_busy_ignored();
    test_reset_mid_request();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
